// File: rtl/gen3_descrambler8.sv
// Per-lane Gen3 128b/130b receive descrambler, one symbol per clock.
// Tracks block framing from sync headers and keeps the 23-bit LFSR in step with the transmitter.
module gen3_descrambler8 #(
  parameter logic [22:0] LFSR_SEED = 23'h1DBFBC,
  parameter logic [7:0]  SKP_SYM   = 8'hAA,
  parameter logic [7:0]  EIEOS_SYM = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  input  logic        block_start_i,
  input  logic [1:0]  sync_hdr_i,
  input  logic        descramble_enable_i,
  output logic        valid_o,
  output logic [7:0]  data_o,
  output logic        block_start_o,
  output logic        is_os_o,
  output logic        sync_err_o,
  output logic [22:0] lfsr_o
);

  localparam int unsigned LFSR_W   = 23;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned BLK_LEN  = 16;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 23'h210125;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    ST_UNALIGNED,
    ST_DATA,
    ST_OS,
    ST_SKP,
    ST_BAD
  } state_t;

  state_t             state_q, state_d, sym_st;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               eieos_q, eieos_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]  lfsr_adv;
  logic [7:0]         keystream;
  logic               reseed;
  logic               skp_len_ok;
  logic               valid_d, block_start_d, is_os_d, sync_err_d;
  logic [7:0]         data_d;

  // Eight serial LFSR steps; returns {keystream byte (bit i = step i), advanced state}.
  function automatic logic [LFSR_W+7:0] lfsr_byte(input logic [LFSR_W-1:0] l);
    logic [LFSR_W-1:0] s;
    logic [7:0]        ks;
    s  = l;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      ks[i] = s[LFSR_W-1];
      s     = {s[LFSR_W-2:0], 1'b0} ^ ({LFSR_W{ks[i]}} & LFSR_POLY);
    end
    return {ks, s};
  endfunction

  assign {keystream, lfsr_adv} = lfsr_byte(lfsr_q);
  assign skp_len_ok = (cnt_q[1:0] == 2'b00) && (cnt_q >= CNT_W'(8)) && (cnt_q <= CNT_W'(24));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_UNALIGNED;
      cnt_q         <= '0;
      eieos_q       <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      valid_o       <= 1'b0;
      data_o        <= '0;
      block_start_o <= 1'b0;
      is_os_o       <= 1'b0;
      sync_err_o    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      eieos_q       <= eieos_d;
      lfsr_q        <= lfsr_d;
      valid_o       <= valid_d;
      data_o        <= data_d;
      block_start_o <= block_start_d;
      is_os_o       <= is_os_d;
      sync_err_o    <= sync_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    eieos_d       = eieos_q;
    lfsr_d        = lfsr_q;
    sym_st        = state_q;
    reseed        = 1'b0;
    valid_d       = valid_i;
    data_d        = data_i;
    block_start_d = 1'b0;
    is_os_d       = 1'b0;
    sync_err_d    = 1'b0;

    if (valid_i) begin
      block_start_d = block_start_i;
      // Symbol 15 of an EIEOS reseeds, even if a new block starts on that slot.
      reseed = descramble_enable_i && (state_q == ST_OS) && eieos_q && (cnt_q == CNT_W'(15));

      if (block_start_i) begin
        if (((state_q == ST_DATA) || (state_q == ST_OS)) && (cnt_q != CNT_W'(BLK_LEN)))
          sync_err_d = 1'b1;
        if ((state_q == ST_SKP) && !skp_len_ok)
          sync_err_d = 1'b1;
        unique case (sync_hdr_i)
          2'b10:   sym_st = ST_DATA;
          2'b01:   sym_st = (data_i == SKP_SYM) ? ST_SKP : ST_OS;
          default: begin
            sym_st     = ST_BAD;
            sync_err_d = 1'b1;
          end
        endcase
        cnt_d   = CNT_W'(1);
        eieos_d = (sync_hdr_i == 2'b01) && (data_i == EIEOS_SYM);
      end else if (((state_q == ST_DATA) || (state_q == ST_OS)) &&
                   (cnt_q >= CNT_W'(BLK_LEN))) begin
        // Overlong block: framing is lost.
        sync_err_d = 1'b1;
        sym_st     = ST_UNALIGNED;
        cnt_d      = '0;
      end else if (((state_q == ST_DATA) || (state_q == ST_OS) || (state_q == ST_SKP)) &&
                   (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      state_d = sym_st;
      unique case (sym_st)
        ST_DATA: begin
          if (descramble_enable_i) begin
            data_d = data_i ^ keystream;
            lfsr_d = lfsr_adv;
          end
        end
        ST_OS: begin
          is_os_d = 1'b1;
          if (descramble_enable_i)
            lfsr_d = lfsr_adv;
        end
        ST_SKP:  is_os_d = 1'b1;
        default: ;
      endcase

      if (reseed)
        lfsr_d = LFSR_SEED;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: tb/tb_gen3_descrambler8.sv
// Randomized self-checking bench for gen3_descrambler8 against a block-level reference model.
module tb_gen3_descrambler8;

  localparam logic [22:0] SEED = 23'h1DBFBC;
  localparam logic [22:0] POLY = 23'h210125;
  localparam int M_UNAL = 0, M_DATA = 1, M_OS = 2, M_SKP = 3, M_BAD = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        block_start_i;
  logic [1:0]  sync_hdr_i;
  logic        descramble_enable_i;
  logic        valid_o;
  logic [7:0]  data_o;
  logic        block_start_o;
  logic        is_os_o;
  logic        sync_err_o;
  logic [22:0] lfsr_o;

  always #5 clk_i = ~clk_i;

  gen3_descrambler8 dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .valid_i             (valid_i),
    .data_i              (data_i),
    .block_start_i       (block_start_i),
    .sync_hdr_i          (sync_hdr_i),
    .descramble_enable_i (descramble_enable_i),
    .valid_o             (valid_o),
    .data_o              (data_o),
    .block_start_o       (block_start_o),
    .is_os_o             (is_os_o),
    .sync_err_o          (sync_err_o),
    .lfsr_o              (lfsr_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_mode;
  int          m_cnt;
  bit          m_eieos;
  logic [22:0] m_lfsr;
  logic        e_valid, e_bs, e_os, e_err;
  logic [7:0]  e_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_UNAL;
    m_cnt   = 0;
    m_eieos = 0;
    m_lfsr  = SEED;
    e_valid = 0; e_bs = 0; e_os = 0; e_err = 0; e_data = 8'h00;
  endtask

  // One byte of keystream: bit i is the LFSR output at serial step i.
  task automatic ks_advance(inout logic [22:0] l, output logic [7:0] ks);
    logic o;
    for (int i = 0; i < 8; i++) begin
      o     = l[22];
      ks[i] = o;
      l     = {l[21:0], 1'b0} ^ ({23{o}} & POLY);
    end
  endtask

  task automatic model_accept(input logic v, input logic [7:0] d, input logic bs,
                              input logic [1:0] hdr, input logic en);
    logic [7:0] ks;
    bit rs;
    e_valid = v; e_bs = 0; e_os = 0; e_err = 0; e_data = d;
    if (!v) return;
    e_bs = bs;
    rs = en && (m_mode == M_OS) && m_eieos && (m_cnt == 15);
    if (bs) begin
      if ((m_mode == M_DATA || m_mode == M_OS) && m_cnt != 16) e_err = 1;
      if (m_mode == M_SKP && !(m_cnt inside {8, 12, 16, 20, 24})) e_err = 1;
      if (hdr == 2'b10) m_mode = M_DATA;
      else if (hdr == 2'b01) m_mode = (d == 8'hAA) ? M_SKP : M_OS;
      else begin m_mode = M_BAD; e_err = 1; end
      m_cnt   = 1;
      m_eieos = (hdr == 2'b01) && (d == 8'h00);
    end else if ((m_mode == M_DATA || m_mode == M_OS) && m_cnt >= 16) begin
      e_err  = 1;
      m_mode = M_UNAL;
      m_cnt  = 0;
    end else if (m_mode == M_DATA || m_mode == M_OS || m_mode == M_SKP) begin
      if (m_cnt < 31) m_cnt++;
    end
    if (m_mode == M_DATA && en) begin
      ks_advance(m_lfsr, ks);
      e_data = d ^ ks;
    end else if (m_mode == M_OS) begin
      e_os = 1;
      if (en) ks_advance(m_lfsr, ks);
    end else if (m_mode == M_SKP) begin
      e_os = 1;
    end
    if (rs) m_lfsr = SEED;
  endtask

  task automatic check_all();
    check_eq("valid_o", 32'(valid_o), 32'(e_valid));
    if (e_valid) check_eq("data_o", 32'(data_o), 32'(e_data));
    check_eq("block_start_o", 32'(block_start_o), 32'(e_bs));
    check_eq("is_os_o", 32'(is_os_o), 32'(e_os));
    check_eq("sync_err_o", 32'(sync_err_o), 32'(e_err));
    check_eq("lfsr_o", 32'(lfsr_o), 32'(m_lfsr));
  endtask

  // Called at a negedge: apply inputs, then check the registered result one cycle later.
  task automatic drive(input logic v, input logic [7:0] d, input logic bs,
                       input logic [1:0] hdr, input logic en);
    valid_i = v; data_i = d; block_start_i = bs; sync_hdr_i = hdr; descramble_enable_i = en;
    model_accept(v, d, bs, hdr, en);
    @(negedge clk_i);
    check_all();
  endtask

  // kind: 0 zeros, 1 random, 2 alternating 00/FF, 3 SKP body (AA.., E1, random)
  task automatic send_block(input logic [1:0] hdr, input logic [7:0] sym0, input int len,
                            input int kind, input logic en, input bit gaps);
    logic [7:0] s;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        drive(1'b0, 8'($urandom), 1'b0, 2'b00, en);
      case (kind)
        0:       s = 8'h00;
        2:       s = (i % 2 == 0) ? 8'h00 : 8'hFF;
        3:       s = (i < len - 4) ? 8'hAA : ((i == len - 4) ? 8'hE1 : 8'($urandom));
        default: s = 8'($urandom);
      endcase
      if (i == 0) s = sym0;
      drive(1'b1, s, i == 0, hdr, en);
    end
  endtask

  initial begin
    logic [7:0] d;
    int t, len;
    logic en;
    rst_i = 1'b1; valid_i = 0; data_i = 0; block_start_i = 0; sync_hdr_i = 0;
    descramble_enable_i = 1;
    model_reset();
    repeat (3) @(negedge clk_i);
    check_all();
    check_eq("reset_lfsr", 32'(lfsr_o), 32'(SEED));
    rst_i = 1'b0;

    // 1: DATA zeros from seed
    drive(1'b1, 8'h00, 1'b1, 2'b10, 1'b1);
    check_eq("t1_first_6c", 32'(data_o), 32'h6C);
    for (int i = 1; i < 16; i++) drive(1'b1, 8'h00, 1'b0, 2'b00, 1'b1);

    // 2: DATA, SKP, DATA
    send_block(2'b10, 8'($urandom), 16, 1, 1'b1, 1'b0);
    send_block(2'b01, 8'hAA, 16, 3, 1'b1, 1'b0);
    send_block(2'b10, 8'($urandom), 16, 1, 1'b1, 1'b0);

    // 3: EIEOS reseed, then zeros restart the keystream
    send_block(2'b01, 8'h00, 16, 2, 1'b1, 1'b0);
    check_eq("t3_reseed", 32'(lfsr_o), 32'(SEED));
    drive(1'b1, 8'h00, 1'b1, 2'b10, 1'b1);
    check_eq("t3_first_6c", 32'(data_o), 32'h6C);
    for (int i = 1; i < 16; i++) drive(1'b1, 8'h00, 1'b0, 2'b00, 1'b1);

    // 4: bad header, then a short DATA block
    drive(1'b1, 8'h5A, 1'b1, 2'b11, 1'b1);
    check_eq("t4_bad_hdr_err", 32'(sync_err_o), 32'h1);
    check_eq("t4_bad_hdr_pass", 32'(data_o), 32'h5A);
    for (int i = 1; i < 16; i++) drive(1'b1, 8'($urandom), 1'b0, 2'b00, 1'b1);
    send_block(2'b10, 8'($urandom), 15, 1, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 2'b10, 1'b1);
    check_eq("t4_short_err", 32'(sync_err_o), 32'h1);
    for (int i = 1; i < 16; i++) drive(1'b1, 8'($urandom), 1'b0, 2'b00, 1'b1);

    // 5: bypass in mid-block
    for (int i = 0; i < 16; i++) begin
      d  = 8'($urandom);
      en = !(i >= 4 && i < 10);
      drive(1'b1, d, i == 0, 2'b10, en);
      if (!en) check_eq("t5_bypass", 32'(data_o), 32'(d));
    end

    // 6: reset at symbol 7
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), i == 0, 2'b10, 1'b1);
    rst_i = 1'b1; valid_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    check_all();
    check_eq("t6_rst_lfsr", 32'(lfsr_o), 32'(SEED));
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0, 2'b00, 1'b1);

    // Random block stream with gaps, odd lengths and bypass
    for (int b = 0; b < 200; b++) begin
      t  = $urandom_range(0, 9);
      en = ($urandom_range(0, 7) != 0);
      len = 16;
      if ($urandom_range(0, 5) == 0) len = 16 + $urandom_range(0, 3) - 1;
      if (t <= 3) send_block(2'b10, 8'($urandom), len, 1, en, 1'b1);
      else if (t <= 5) begin
        d = 8'($urandom);
        if (d == 8'hAA) d = 8'h2D;
        send_block(2'b01, d, len, 1, en, 1'b1);
      end else if (t == 6) send_block(2'b01, 8'h00, len, 2, en, 1'b1);
      else if (t <= 8) begin
        len = 8 + 4 * $urandom_range(0, 4);
        if ($urandom_range(0, 5) == 0) len = 10;
        send_block(2'b01, 8'hAA, len, 3, en, 1'b1);
      end else send_block(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 8'($urandom), 16, 1, en, 1'b1);
    end
    drive(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
